// File: rtl/key_load_pkg.sv
// Shared types and constants for the serial key loader and its CRC engine.
// The CRC step is defined once here so that the engine and any future user agree on it.
package key_load_pkg;

    localparam int              CRC_W    = 4;
    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_KEY,
        SHIFT_CRC,
        CHECK,
        READY,
        FAIL,
        LOCKOUT
    } state_t;

    // One serial step of x^4+x+1, MSB-first, no reflection.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 accumulator over the key field.
// Clear takes priority over enable so a session restart always starts from zero.
module crc4_serial
    import key_load_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_data,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] r_crc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_crc <= '0;
        end else if (i_clear) begin
            r_crc <= '0;
        end else if (i_enable) begin
            r_crc <= crc_step(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/key_stream_loader.sv
// Serial key loader: shifts in key + CRC-4, verifies, and releases the controller reset
// only while a verified key is held; repeated CRC failures latch a permanent lockout.
//
// state     | meaning
// IDLE      | no key yet, waiting for load_start
// SHIFT_KEY | accepting key bits, MSB first
// SHIFT_CRC | accepting the 4 CRC bits, MSB first
// CHECK     | one-cycle compare of received vs computed CRC
// READY     | verified key on key_out, controller released
// FAIL      | last session failed CRC, waiting for a retry
// LOCKOUT   | too many consecutive failures, left only by rst
module key_stream_loader
    import key_load_pkg::*;
#(
    parameter int KEY_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             core_rst,
    output logic             load_err,
    output logic             lockout
);

    // Counter must also reach CRC_W-1 when KEY_W is tiny.
    localparam int               CNT_W      = ($clog2(KEY_W + 1) > 3) ? $clog2(KEY_W + 1) : 3;
    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_W - 1);
    localparam logic [3:0]       FAIL_LIMIT = 4'(MAX_FAIL);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [KEY_W-1:0] r_shift;
    logic [CRC_W-1:0] r_rx_crc;
    logic [3:0]       r_fail_cnt;
    logic [3:0]       w_fail_next;
    logic [KEY_W-1:0] r_key_out;
    logic             r_key_valid;
    logic             r_core_rst;
    logic             r_load_err;
    logic             r_lockout;
    logic             r_sin_ready;
    logic             w_key_valid_d;
    logic             w_core_rst_d;
    logic             w_load_err_d;
    logic             w_lockout_d;
    logic             w_sin_ready_d;
    logic             w_restart;
    logic             w_xfer;
    logic             w_crc_ok;
    logic [CRC_W-1:0] w_crc;

    assign w_restart   = load_start && (r_state != CHECK) && (r_state != LOCKOUT);
    // load_start wins over a coincident bit, which is simply dropped.
    assign w_xfer      = sin_valid && r_sin_ready && !load_start;
    assign w_crc_ok    = (w_crc == r_rx_crc);
    assign w_fail_next = r_fail_cnt + 4'd1;

    crc4_serial u_crc (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_restart),
        .i_enable (w_xfer && (r_state == SHIFT_KEY)),
        .i_data   (sin_data),
        .o_crc    (w_crc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_key_valid <= 1'b0;
            r_core_rst  <= 1'b1;
            r_load_err  <= 1'b0;
            r_lockout   <= 1'b0;
            r_sin_ready <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_key_valid <= w_key_valid_d;
            r_core_rst  <= w_core_rst_d;
            r_load_err  <= w_load_err_d;
            r_lockout   <= w_lockout_d;
            r_sin_ready <= w_sin_ready_d;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_start) w_next_state = SHIFT_KEY;
            end
            SHIFT_KEY: begin
                if (load_start)                          w_next_state = SHIFT_KEY;
                else if (w_xfer && (r_cnt == KEY_LAST))  w_next_state = SHIFT_CRC;
            end
            SHIFT_CRC: begin
                if (load_start)                          w_next_state = SHIFT_KEY;
                else if (w_xfer && (r_cnt == CRC_LAST))  w_next_state = CHECK;
            end
            CHECK: begin
                if (w_crc_ok)                            w_next_state = READY;
                else if (w_fail_next == FAIL_LIMIT)      w_next_state = LOCKOUT;
                else                                     w_next_state = FAIL;
            end
            READY, FAIL: begin
                if (load_start) w_next_state = SHIFT_KEY;
            end
            LOCKOUT: w_next_state = LOCKOUT;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        w_key_valid_d = (w_next_state == READY);
        w_core_rst_d  = (w_next_state != READY);
        w_load_err_d  = (w_next_state == FAIL);
        w_lockout_d   = (w_next_state == LOCKOUT);
        w_sin_ready_d = (w_next_state == SHIFT_KEY) || (w_next_state == SHIFT_CRC);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_rx_crc   <= '0;
            r_fail_cnt <= '0;
            r_key_out  <= '0;
        end else if (w_restart) begin
            r_cnt    <= '0;
            r_shift  <= '0;
            r_rx_crc <= '0;
        end else begin
            case (r_state)
                SHIFT_KEY: begin
                    if (w_xfer) begin
                        r_shift <= (r_shift << 1) | KEY_W'(sin_data);
                        r_cnt   <= (r_cnt == KEY_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                SHIFT_CRC: begin
                    if (w_xfer) begin
                        r_rx_crc <= {r_rx_crc[CRC_W-2:0], sin_data};
                        r_cnt    <= (r_cnt == CRC_LAST) ? '0 : r_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (w_crc_ok) begin
                        r_key_out  <= r_shift;
                        r_fail_cnt <= '0;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sin_ready = r_sin_ready;
    assign key_out   = r_key_out;
    assign key_valid = r_key_valid;
    assign core_rst  = r_core_rst;
    assign load_err  = r_load_err;
    assign lockout   = r_lockout;

endmodule
